// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one signed saturating adder among N_REQ requesters.
// Holds a registered result (sum, requester ID, clip flag) and counts saturating transfers.
module sat_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 14,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  aclk,
  input  logic                  rstn_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*DW-1:0]   req_a_i,
  input  logic [N_REQ*DW-1:0]   req_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DW-1:0]         res_dat_o,
  output logic [IDW-1:0]        res_id_o,
  output logic                  res_sat_o,
  input  logic                  clr_i,
  output logic [15:0]           sat_cnt_o
);

  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [15:0]   CNT_MAX = 16'hFFFF;

  // Index base+off modulo N_REQ; both operands are below N_REQ so one subtraction suffices.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      return IDW'(sum - N_REQ);
    end else begin
      return IDW'(sum);
    end
  endfunction

  // Returns {sat, result}: clips to the signed range when the two top sum bits disagree.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    logic [DW:0] res;
    sum = {a[DW-1], a} + {b[DW-1], b};
    case (sum[DW:DW-1])
      2'b01:   res = {1'b1, MAX_POS};
      2'b10:   res = {1'b1, MAX_NEG};
      default: res = {1'b0, sum[DW-1:0]};
    endcase
    return res;
  endfunction

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;
  logic [DW-1:0]    res_dat_q, res_dat_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             res_sat_q, res_sat_d;
  logic [15:0]      sat_cnt_q, sat_cnt_d;

  logic             found_s;
  logic [IDW-1:0]   grant_s;
  logic             free_s;
  logic             accept_s;
  logic [N_REQ-1:0] ready_s;
  logic [DW-1:0]    a_s;
  logic [DW-1:0]    b_s;
  logic [DW:0]      add_s;
  logic             sat_s;

  // Grant search: first valid requester at or after ptr_q, wrapping around
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && req_valid_i[wrap_idx(ptr_q, k)]) begin
        found_s = 1'b1;
        grant_s = wrap_idx(ptr_q, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake: the result slot can take a new sum when empty or being drained
  always_comb begin
    free_s  = ~res_valid_q | res_ready_i;
    ready_s = '0;
    if (found_s) begin
      ready_s[grant_s] = free_s;
    end else begin
      ready_s = '0;
    end
    accept_s = found_s & free_s;
  end

  // Shared adder fed by the granted requester's operand pair
  always_comb begin
    a_s   = req_a_i[int'(grant_s)*DW +: DW];
    b_s   = req_b_i[int'(grant_s)*DW +: DW];
    add_s = sat_add(a_s, b_s);
    sat_s = add_s[DW];
  end

  // Next-state for result slot and pointer; pointer only advances on an accept
  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_dat_d   = res_dat_q;
    res_id_d    = res_id_q;
    res_sat_d   = res_sat_q;
    if (accept_s) begin
      res_valid_d = 1'b1;
      res_dat_d   = add_s[DW-1:0];
      res_id_d    = grant_s;
      res_sat_d   = sat_s;
      if (grant_s == IDW'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_s + IDW'(1);
      end
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Saturation counter: clear wins over increment but still counts a same-cycle event
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_i) begin
      sat_cnt_d = (accept_s && sat_s) ? 16'd1 : 16'd0;
    end else if (accept_s && sat_s && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // State registers
  always_ff @(posedge aclk or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_dat_q   <= '0;
      res_id_q    <= '0;
      res_sat_q   <= 1'b0;
      sat_cnt_q   <= 16'd0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_dat_q   <= res_dat_d;
      res_id_q    <= res_id_d;
      res_sat_q   <= res_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign req_ready_o = ready_s;
  assign res_valid_o = res_valid_q;
  assign res_dat_o   = res_dat_q;
  assign res_id_o    = res_id_q;
  assign res_sat_o   = res_sat_q;
  assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Scoreboard bench for sat_add_arbiter: a cycle model predicts grants and sums,
// a monitor pops expected results whenever the DUT hands one to the consumer.
module tb_sat_add_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 14;
  localparam int IDW   = 2;
  localparam int MAXP  = (1 << (DW - 1)) - 1;
  localparam int MINN  = -(1 << (DW - 1));

  logic                aclk = 1'b0;
  logic                rstn;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic                res_ready;
  logic                clr;
  logic [N_REQ-1:0]    req_ready_o;
  logic                res_valid_o;
  logic [DW-1:0]       res_dat_o;
  logic [IDW-1:0]      res_id_o;
  logic                res_sat_o;
  logic [15:0]         sat_cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] dat;
    logic          sat;
  } exp_t;
  exp_t exp_q[$];

  logic [N_REQ-1:0] acc_last = '0;

  always #5 aclk = ~aclk;

  sat_add_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
    .aclk        (aclk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready),
    .res_dat_o   (res_dat_o),
    .res_id_o    (res_id_o),
    .res_sat_o   (res_sat_o),
    .clr_i       (clr),
    .sat_cnt_o   (sat_cnt_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b);
    req_valid[i]        = v;
    req_a[i*DW +: DW]   = DW'(a);
    req_b[i*DW +: DW]   = DW'(b);
  endtask

  // Reference model: spec-level arbitration and arithmetic, evaluated mid-cycle
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  int          m_cnt   = 0;
  always @(negedge aclk) begin
    int g;
    int idx;
    int s;
    logic free;
    logic sat;
    logic [N_REQ-1:0] er;
    logic signed [DW-1:0] av;
    logic signed [DW-1:0] bv;
    exp_t e;
    if (!rstn) begin
      m_ptr = 0; m_valid = 1'b0; m_cnt = 0;
      exp_q.delete();
      chk("rst_valid", 32'(res_valid_o), 32'd0);
      chk("rst_cnt", 32'(sat_cnt_o), 32'd0);
    end else begin
      chk("res_valid", 32'(res_valid_o), 32'(m_valid));
      chk("sat_cnt", 32'(sat_cnt_o), 32'(m_cnt));
      free = !m_valid || res_ready;
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      er = '0;
      if (g >= 0 && free) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready_o), 32'(er));
      sat = 1'b0;
      if (g >= 0 && free) begin
        av = req_a[g*DW +: DW];
        bv = req_b[g*DW +: DW];
        s  = int'(av) + int'(bv);
        if (s > MAXP) begin s = MAXP; sat = 1'b1; end
        else if (s < MINN) begin s = MINN; sat = 1'b1; end
        e.id = g; e.dat = s[DW-1:0]; e.sat = sat;
        exp_q.push_back(e);
        m_ptr = (g + 1) % N_REQ;
        m_valid = 1'b1;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
      if (clr) m_cnt = sat ? 1 : 0;
      else if (sat && m_cnt < 65535) m_cnt++;
    end
  end

  // Monitor: compare each result as the consumer takes it
  always @(negedge aclk) begin
    exp_t e;
    if (rstn && res_valid_o && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: got result id %0d dat %0h expected none", res_id_o, res_dat_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dat", 32'(res_dat_o), 32'(e.dat));
        chk("sb_id", 32'(res_id_o), 32'(e.id));
        chk("sb_sat", 32'(res_sat_o), 32'(e.sat));
      end
    end
  end

  // Records which requesters were accepted so the random drivers respect the hold rule
  always @(negedge aclk) acc_last = rstn ? (req_valid & req_ready_o) : '0;

  initial begin
    rstn = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0; clr = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_dat", 32'(res_dat_o), 32'd0);
    chk("reset_id", 32'(res_id_o), 32'd0);
    chk("reset_sat", 32'(res_sat_o), 32'd0);
    rstn = 1'b1;
    res_ready = 1'b1;
    repeat (10) cyc();
    chk("idle_valid", 32'(res_valid_o), 32'd0);
    chk("idle_cnt", 32'(sat_cnt_o), 32'd0);

    // Single add on requester 2
    set_req(2, 1'b1, 100, -300);
    #1 chk("single_ready", 32'(req_ready_o), 32'h4);
    cyc();
    req_valid[2] = 1'b0;
    chk("single_valid", 32'(res_valid_o), 32'd1);
    chk("single_dat", 32'(res_dat_o), 32'h3F38);
    chk("single_id", 32'(res_id_o), 32'd2);
    chk("single_sat", 32'(res_sat_o), 32'd0);
    cyc();
    chk("single_drop", 32'(res_valid_o), 32'd0);
    chk("single_hold_dat", 32'(res_dat_o), 32'h3F38);

    // Saturation in both directions, then clear
    set_req(0, 1'b1, 32'h1000, 32'h1000);
    #1 chk("satp_ready", 32'(req_ready_o), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'h2000, 32'h3FFF);
    chk("satp_dat", 32'(res_dat_o), 32'h1FFF);
    chk("satp_sat", 32'(res_sat_o), 32'd1);
    chk("satp_id", 32'(res_id_o), 32'd0);
    cyc();
    req_valid[1] = 1'b0;
    chk("satn_dat", 32'(res_dat_o), 32'h2000);
    chk("satn_sat", 32'(res_sat_o), 32'd1);
    chk("satn_id", 32'(res_id_o), 32'd1);
    chk("sat_cnt_two", 32'(sat_cnt_o), 32'd2);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("sat_cnt_clr", 32'(sat_cnt_o), 32'd0);

    // Move pointer back to 0, then all four requesters continuously valid
    set_req(3, 1'b1, 1, 1);
    cyc();
    req_valid[3] = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i, 1);
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_onehot", 32'($countones(req_ready_o)), 32'd1);
      cyc();
      chk("rr_id", 32'(res_id_o), 32'(k % N_REQ));
      chk("rr_valid", 32'(res_valid_o), 32'd1);
    end
    req_valid = '0;
    cyc();

    // Backpressure: pointer to 1 first, then requesters 1 and 3
    set_req(0, 1'b1, 5, 5);
    cyc();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, int'($urandom), int'($urandom));
    set_req(3, 1'b1, int'($urandom), int'($urandom));
    cyc();
    req_valid[1] = 1'b0;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(req_ready_o), 32'd0);
      chk("bp_id", 32'(res_id_o), 32'd1);
      chk("bp_valid", 32'(res_valid_o), 32'd1);
      cyc();
    end
    res_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready_o), 32'h8);
    cyc();
    req_valid[3] = 1'b0;
    chk("bp_next_id", 32'(res_id_o), 32'd3);
    chk("bp_next_valid", 32'(res_valid_o), 32'd1);
    cyc();

    // Counter saturates at 0xFFFF; clear with a same-cycle saturating accept gives 1
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    set_req(0, 1'b1, 32'h1FFF, 32'h1FFF);
    repeat (65537) cyc();
    chk("cnt_stick", 32'(sat_cnt_o), 32'hFFFF);
    cyc();
    chk("cnt_stick2", 32'(sat_cnt_o), 32'hFFFF);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("cnt_clr_acc", 32'(sat_cnt_o), 32'd1);
    req_valid = '0;
    cyc();

    // Random traffic with a mid-stream reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!(req_valid[i] && !acc_last[i])) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1'b1, int'($urandom), int'($urandom));
          else
            req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      if (c == 1500) begin
        res_ready = 1'b0;
        repeat (3) cyc();
        rstn = 1'b0;
        #1 chk("mid_rst_valid", 32'(res_valid_o), 32'd0);
        req_valid = '1;
        cyc();
        cyc();
        rstn = 1'b1;
        #1 chk("post_rst_grant", 32'(req_ready_o), 32'h1);
      end
      cyc();
    end

    req_valid = '0; res_ready = 1'b1; clr = 1'b0;
    repeat (3) cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
